// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two memory requesters (CPU port c, loader port d),
// the arbiter and the unified memory array.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // CPU port
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_ack;
  logic [DATA_W-1:0] c_rdata;
  logic              cpu_stall;
  // Loader / DMA port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  // Memory side
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_ack, c_rdata, cpu_stall,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  // Requester/memory view
  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_ack, c_rdata, cpu_stall,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing the unified MIPS memory between the CPU (port c) and the
// program loader (port d). Each access runs IDLE -> ACCESS -> DONE; the ack
// pulses in DONE, where the other port may be granted back-to-back.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter bit          RR_EN  = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic PortC = 1'b0;
  localparam logic PortD = 1'b1;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              grant;
  logic              grant_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] c_rdata_q, d_rdata_q;
  logic              c_ack_q, d_ack_q;

  // Next-state and grant decision
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    grant      = 1'b0;
    grant_port = PortC;
    unique case (state_q)
      StIdle: begin
        if (bus.c_req || bus.d_req) begin
          grant = 1'b1;
          if (bus.c_req && bus.d_req) begin
            grant_port = RR_EN ? ~last_q : PortC;
          end else begin
            grant_port = bus.d_req ? PortD : PortC;
          end
        end
      end
      StAccess: state_d = StDone;
      StDone: begin
        // Owner's req is still up during its ack cycle and is ignored here.
        // Under fixed priority a waiting loader goes back through IDLE, where
        // the CPU gets first look, so a busy CPU starves the loader.
        if (owner_q == PortD && bus.c_req) begin
          grant      = 1'b1;
          grant_port = PortC;
        end else if (owner_q == PortC && bus.d_req && RR_EN) begin
          grant      = 1'b1;
          grant_port = PortD;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (grant) begin
      state_d = StAccess;
      owner_d = grant_port;
      last_d  = grant_port;
    end
  end

  assign sel_we    = (grant_port == PortD) ? bus.d_we    : bus.c_we;
  assign sel_addr  = (grant_port == PortD) ? bus.d_addr  : bus.c_addr;
  assign sel_wdata = (grant_port == PortD) ? bus.d_wdata : bus.c_wdata;

  // Control state register; CPU wins the first tie after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= PortC;
      last_q  <= PortD;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Memory request latch, read-data capture and ack generation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      c_rdata_q   <= '0;
      d_rdata_q   <= '0;
      c_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      if (grant) begin
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
        mem_we_q    <= sel_we;
      end else if (state_q == StAccess) begin
        mem_we_q <= 1'b0;
      end
      // Reads only; a write leaves the owner's last read data in place
      if (state_q == StAccess && !mem_we_q) begin
        if (owner_q == PortD) begin
          d_rdata_q <= bus.mem_rdata;
        end else begin
          c_rdata_q <= bus.mem_rdata;
        end
      end
      c_ack_q <= (state_q == StAccess) && (owner_q == PortC);
      d_ack_q <= (state_q == StAccess) && (owner_q == PortD);
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.c_rdata   = c_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.c_ack     = c_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.cpu_stall = bus.c_req & ~c_ack_q;

endmodule
